// File: rtl/pixel_rgb_formatter_if.sv
// Pixel stream bundle for pixel_rgb_formatter.
// Carries the upstream pixel (coordinates, float colour, coverage and
// overlay sideband) with its valid/ready pair, and the formatted
// downstream pixel with its valid/ready pair.
// master: the side that produces input pixels and consumes output pixels.
// slave : the formatter itself.
interface pixel_rgb_formatter_if #(
  parameter int OUT_BITS  = 4,
  parameter int N_OVERLAY = 1,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
);
  logic                            valid_in;
  logic                            ready_out;
  logic [X_W-1:0]                  x_in;
  logic [Y_W-1:0]                  y_in;
  logic [31:0]                     r_in;
  logic [31:0]                     g_in;
  logic [31:0]                     b_in;
  logic                            block_visible_in;
  logic [N_OVERLAY-1:0]            overlay_hit_in;
  logic [N_OVERLAY*3*OUT_BITS-1:0] overlay_rgb_in;
  logic [X_W-1:0]                  x_out;
  logic [Y_W-1:0]                  y_out;
  logic [OUT_BITS-1:0]             r_out;
  logic [OUT_BITS-1:0]             g_out;
  logic [OUT_BITS-1:0]             b_out;
  logic                            visible_out;
  logic                            valid_out;
  logic                            ready_in;

  modport master (
    output valid_in, x_in, y_in, r_in, g_in, b_in, block_visible_in,
           overlay_hit_in, overlay_rgb_in, ready_in,
    input  ready_out, x_out, y_out, r_out, g_out, b_out, visible_out, valid_out
  );

  modport slave (
    input  valid_in, x_in, y_in, r_in, g_in, b_in, block_visible_in,
           overlay_hit_in, overlay_rgb_in, ready_in,
    output ready_out, x_out, y_out, r_out, g_out, b_out, visible_out, valid_out
  );
endinterface

// File: rtl/pixel_rgb_formatter.sv
// pixel_rgb_formatter: converts IEEE-754 single-precision colour channels
// in nominal [0,1] into OUT_BITS-wide integer codes and applies a
// prioritised constant-colour overlay.
//
// Pipeline (one register level per stage, all advancing together):
//   S1 classify/clamp : NaN, negative and zero/denormal map to 0, values
//                       >= 1.0 (and +inf) map to the max code, everything
//                       else keeps its 24-bit significand and a shift.
//   S2 scale          : significand * (2^OUT_BITS-1), exact integer product.
//   S3 quantise/mux   : shift the product down to the code, then let the
//                       lowest-index hit overlay override the colour.
// The whole pipeline stalls on (valid_out && !ready_in); ready_out is that
// advance enable.
//
// Build option: define PIXEL_FMT_ROUND_EN to round half-up instead of
// truncating the fractional conversion (latency is unchanged).
module pixel_rgb_formatter #(
  parameter int OUT_BITS  = 4,
  parameter int N_OVERLAY = 1,
  parameter int X_W       = 11,
  parameter int Y_W       = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  pixel_rgb_formatter_if.slave  bus
);

  localparam int OVL_W     = 3 * OUT_BITS;
  localparam int OVL_ALL_W = N_OVERLAY * OVL_W;

  localparam logic [OUT_BITS-1:0] MAX_CODE    = {OUT_BITS{1'b1}};
  localparam logic [31:0]         MAX_CODE_32 = {{(32-OUT_BITS){1'b0}}, MAX_CODE};
  localparam logic [63:0]         MAX_CODE_64 = {32'd0, MAX_CODE_32};

  // Channel classes decided in S1.
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_MAX  = 2'd1;
  localparam logic [1:0] CLS_FRAC = 2'd2;

  // Classify a float channel: which of the three conversion paths it takes.
  function automatic logic [1:0] classify(input logic [31:0] f);
    logic [7:0]  e;
    logic [22:0] m;
    e = f[30:23];
    m = f[22:0];
    if (e == 8'hFF && m != 23'd0) begin
      return CLS_ZERO;          // NaN
    end else if (f[31]) begin
      return CLS_ZERO;          // any negative, including -0 and -inf
    end else if (e == 8'd0) begin
      return CLS_ZERO;          // zero and denormals
    end else if (e >= 8'd127) begin
      return CLS_MAX;           // >= 1.0, including +inf
    end else begin
      return CLS_FRAC;
    end
  endfunction

  // For 0 < v < 1, v = sig24 * 2^(e-150): right shift of sig*max is 150-e.
  // Shifts beyond 63 all produce code 0, so they are clamped to 63.
  function automatic logic [5:0] frac_shift(input logic [7:0] e);
    logic [8:0] s;
    s = 9'd150 - {1'b0, e};
    if (s > 9'd63) begin
      return 6'd63;
    end else begin
      return s[5:0];
    end
  endfunction

  // Reduce the scaled product to the output code for one channel.
  function automatic logic [OUT_BITS-1:0] quantise(input logic [1:0]  cls,
                                                   input logic [31:0] prod,
                                                   input logic [5:0]  sh);
    logic [63:0] acc;
    logic [63:0] q;
    acc = {32'd0, prod};
`ifdef PIXEL_FMT_ROUND_EN
    // Fractional codes always have sh >= 24, so sh-1 never underflows.
    acc = acc + (64'd1 << (sh - 6'd1));
`endif
    q = acc >> sh;
    if (q > MAX_CODE_64) begin
      q = MAX_CODE_64;
    end else begin
      q = q;
    end
    case (cls)
      CLS_ZERO: return {OUT_BITS{1'b0}};
      CLS_MAX:  return MAX_CODE;
      CLS_FRAC: return q[OUT_BITS-1:0];
      default:  return {OUT_BITS{1'b0}};
    endcase
  endfunction

  // ---------------------------------------------------------------- control
  logic en_s;

  // S1 registers
  logic                 s1_valid_r;
  logic [X_W-1:0]       s1_x_r;
  logic [Y_W-1:0]       s1_y_r;
  logic                 s1_vis_r;
  logic [N_OVERLAY-1:0] s1_hit_r;
  logic [OVL_ALL_W-1:0] s1_ovl_r;
  logic [1:0]           s1_cls_r   [3];
  logic [23:0]          s1_sig_r   [3];
  logic [5:0]           s1_shift_r [3];

  // S2 registers
  logic                 s2_valid_r;
  logic [X_W-1:0]       s2_x_r;
  logic [Y_W-1:0]       s2_y_r;
  logic                 s2_vis_r;
  logic [N_OVERLAY-1:0] s2_hit_r;
  logic [OVL_ALL_W-1:0] s2_ovl_r;
  logic [1:0]           s2_cls_r   [3];
  logic [31:0]          s2_prod_r  [3];
  logic [5:0]           s2_shift_r [3];

  // S3 / output registers
  logic                 valid_out_r;
  logic [X_W-1:0]       x_out_r;
  logic [Y_W-1:0]       y_out_r;
  logic [OUT_BITS-1:0]  r_out_r;
  logic [OUT_BITS-1:0]  g_out_r;
  logic [OUT_BITS-1:0]  b_out_r;
  logic                 visible_out_r;

  // Combinational stage inputs
  logic [31:0]          chan_in_s  [3];
  logic [1:0]           s1_cls_s   [3];
  logic [23:0]          s1_sig_s   [3];
  logic [5:0]           s1_shift_s [3];
  logic [31:0]          s2_prod_s  [3];
  logic [OUT_BITS-1:0]  q_s        [3];
  logic                 hit_any_s;
  logic [OVL_W-1:0]     ovl_sel_s;
  logic [OUT_BITS-1:0]  r_nxt_s;
  logic [OUT_BITS-1:0]  g_nxt_s;
  logic [OUT_BITS-1:0]  b_nxt_s;
  logic                 vis_nxt_s;

  // Whole pipeline advances unless the output holds an unaccepted pixel.
  assign en_s          = !valid_out_r || bus.ready_in;
  assign bus.ready_out = en_s;

  assign bus.valid_out   = valid_out_r;
  assign bus.x_out       = x_out_r;
  assign bus.y_out       = y_out_r;
  assign bus.r_out       = r_out_r;
  assign bus.g_out       = g_out_r;
  assign bus.b_out       = b_out_r;
  assign bus.visible_out = visible_out_r;

  // ---------------------------------------------------------------- S1
  // Classify each incoming channel and extract significand and shift.
  always_comb begin
    chan_in_s[0] = bus.r_in;
    chan_in_s[1] = bus.g_in;
    chan_in_s[2] = bus.b_in;
    for (int c = 0; c < 3; c++) begin
      s1_cls_s[c]   = classify(chan_in_s[c]);
      s1_sig_s[c]   = {1'b1, chan_in_s[c][22:0]};
      s1_shift_s[c] = frac_shift(chan_in_s[c][30:23]);
    end
  end

  // S1 register: capture accepted pixels, hold everything on stall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= {X_W{1'b0}};
      s1_y_r     <= {Y_W{1'b0}};
      s1_vis_r   <= 1'b0;
      s1_hit_r   <= {N_OVERLAY{1'b0}};
      s1_ovl_r   <= {OVL_ALL_W{1'b0}};
      for (int c = 0; c < 3; c++) begin
        s1_cls_r[c]   <= CLS_ZERO;
        s1_sig_r[c]   <= 24'd0;
        s1_shift_r[c] <= 6'd0;
      end
    end else if (en_s) begin
      s1_valid_r <= bus.valid_in;
      if (bus.valid_in) begin
        s1_x_r   <= bus.x_in;
        s1_y_r   <= bus.y_in;
        s1_vis_r <= bus.block_visible_in;
        s1_hit_r <= bus.overlay_hit_in;
        s1_ovl_r <= bus.overlay_rgb_in;
        for (int c = 0; c < 3; c++) begin
          s1_cls_r[c]   <= s1_cls_s[c];
          s1_sig_r[c]   <= s1_sig_s[c];
          s1_shift_r[c] <= s1_shift_s[c];
        end
      end
    end
  end

  // ---------------------------------------------------------------- S2
  // Exact scale by the max code; 24-bit sig times <= 8-bit max fits 32 bits.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      s2_prod_s[c] = {8'd0, s1_sig_r[c]} * MAX_CODE_32;
    end
  end

  // S2 register: carry the scaled product and sideband in lockstep.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid_r <= 1'b0;
      s2_x_r     <= {X_W{1'b0}};
      s2_y_r     <= {Y_W{1'b0}};
      s2_vis_r   <= 1'b0;
      s2_hit_r   <= {N_OVERLAY{1'b0}};
      s2_ovl_r   <= {OVL_ALL_W{1'b0}};
      for (int c = 0; c < 3; c++) begin
        s2_cls_r[c]   <= CLS_ZERO;
        s2_prod_r[c]  <= 32'd0;
        s2_shift_r[c] <= 6'd0;
      end
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_x_r   <= s1_x_r;
        s2_y_r   <= s1_y_r;
        s2_vis_r <= s1_vis_r;
        s2_hit_r <= s1_hit_r;
        s2_ovl_r <= s1_ovl_r;
        for (int c = 0; c < 3; c++) begin
          s2_cls_r[c]   <= s1_cls_r[c];
          s2_prod_r[c]  <= s2_prod_s[c];
          s2_shift_r[c] <= s1_shift_r[c];
        end
      end
    end
  end

  // ---------------------------------------------------------------- S3
  // Quantise each channel from its scaled product.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      q_s[c] = quantise(s2_cls_r[c], s2_prod_r[c], s2_shift_r[c]);
    end
  end

  // Overlay mux: scanning from the top down leaves the lowest hit index.
  always_comb begin
    hit_any_s = 1'b0;
    ovl_sel_s = {OVL_W{1'b0}};
    for (int i = N_OVERLAY - 1; i >= 0; i--) begin
      hit_any_s = hit_any_s | s2_hit_r[i];
      ovl_sel_s = s2_hit_r[i] ? s2_ovl_r[i*OVL_W +: OVL_W] : ovl_sel_s;
    end
    if (hit_any_s) begin
      r_nxt_s   = ovl_sel_s[3*OUT_BITS-1 -: OUT_BITS];
      g_nxt_s   = ovl_sel_s[2*OUT_BITS-1 -: OUT_BITS];
      b_nxt_s   = ovl_sel_s[OUT_BITS-1:0];
      vis_nxt_s = 1'b1;
    end else begin
      r_nxt_s   = q_s[0];
      g_nxt_s   = q_s[1];
      b_nxt_s   = q_s[2];
      vis_nxt_s = s2_vis_r;
    end
  end

  // Output register: data only changes when a valid pixel moves in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_out_r   <= 1'b0;
      x_out_r       <= {X_W{1'b0}};
      y_out_r       <= {Y_W{1'b0}};
      r_out_r       <= {OUT_BITS{1'b0}};
      g_out_r       <= {OUT_BITS{1'b0}};
      b_out_r       <= {OUT_BITS{1'b0}};
      visible_out_r <= 1'b0;
    end else if (en_s) begin
      valid_out_r <= s2_valid_r;
      if (s2_valid_r) begin
        x_out_r       <= s2_x_r;
        y_out_r       <= s2_y_r;
        r_out_r       <= r_nxt_s;
        g_out_r       <= g_nxt_s;
        b_out_r       <= b_nxt_s;
        visible_out_r <= vis_nxt_s;
      end
    end
  end

endmodule

// File: doc/pixel_rgb_formatter.md
PIXEL_RGB_FORMATTER -- requirements
Module: pixel_rgb_formatter

Interface
REQ-001 SHALL have parameter OUT_BITS, default 4, bits per output colour channel (legal 1..8).
REQ-002 SHALL have parameter N_OVERLAY, default 1, number of prioritised constant-colour overlay channels (legal 1..4).
REQ-003 SHALL have parameter X_W, default 11, x coordinate width; parameter Y_W, default 10, y coordinate width.
REQ-004 Ports:
 clk_in  input  1  sole clock.
 rst_n_in  input  1  asynchronous, active-low reset.
 valid_in  input  1  upstream pixel valid.
 ready_out  output  1  block accepts the upstream pixel this cycle.
 x_in  input  X_W  pixel x.
 y_in  input  Y_W  pixel y.
 r_in, g_in, b_in  input  32 each  IEEE-754 single colour components, nominal [0,1].
 block_visible_in  input  1  pixel covered by geometry.
 overlay_hit_in  input  N_OVERLAY  per-overlay coverage flags.
 overlay_rgb_in  input  N_OVERLAY*3*OUT_BITS  per-overlay colour {r,g,b}, overlay 0 in LSBs.
 x_out  output  X_W  pixel x.
 y_out  output  Y_W  pixel y.
 r_out, g_out, b_out  output  OUT_BITS each  formatted colour.
 visible_out  output  1  pixel to be drawn.
 valid_out  output  1  output pixel valid.
 ready_in  input  1  downstream accepts output.

Function
REQ-005 SHALL be a 3-stage pipeline: S1 classify/clamp, S2 scale, S3 quantise + overlay mux; latency exactly 3 cycles from accepted input to valid_out when not stalled.
REQ-006 Pipeline advance enable SHALL be (!valid_out || ready_in); ready_out SHALL equal this enable (combinational).
REQ-007 When enable is low, all stage registers, valid bits and outputs SHALL hold; no pixel dropped or duplicated.
REQ-008 Input SHALL be accepted iff valid_in && ready_out; a bubble (valid_in=0) SHALL propagate as an invalid stage.
REQ-009 valid_out, once high, SHALL stay high with stable data until ready_in is sampled high.
REQ-010 Clamp per channel: NaN -> 0; sign bit set (incl. -0, -inf) -> 0; exponent 0 (zero/denormal) -> 0; value >= 1.0 or +inf -> max code (2^OUT_BITS-1); otherwise convert as REQ-011.
REQ-011 For 0 < v < 1.0, code SHALL equal floor(v * (2^OUT_BITS-1)) computed exactly from the 24-bit significand (no float IP).
REQ-012 x, y, block_visible_in, overlay_hit_in, overlay_rgb_in SHALL be carried in lockstep with their colour data through all stages.
REQ-013 Overlay mux: lowest index i with overlay_hit set SHALL win; outputs = overlay i colour, visible_out = 1.
REQ-014 With no overlay hit: outputs = quantised colour, visible_out = block_visible_in of that pixel.
REQ-015 Outputs while valid_out = 0 SHALL hold last value (don't-care for checking except valid_out).

Reset
REQ-016 rst_n_in low SHALL asynchronously clear all stage valid bits, valid_out, x_out, y_out, r_out, g_out, b_out, visible_out to 0.
REQ-017 Pixels in flight at reset assertion SHALL be discarded; none emerge after release.
REQ-018 ready_out SHALL be 1 during and after reset (valid_out = 0).
REQ-019 First accepted pixel after reset release SHALL appear after exactly 3 cycles.

Configuration
REQ-020 Macro PIXEL_FMT_ROUND_EN defined: REQ-011 code SHALL be round-half-up, floor(v*(2^OUT_BITS-1) + 0.5), saturated to max code; latency unchanged.
REQ-021 Macro PIXEL_FMT_ROUND_EN undefined: truncation per REQ-011.

Verification (OUT_BITS=4, N_OVERLAY=2)
REQ-022 r/g/b = 0x3F000000 (0.5), 0x3F800000 (1.0), 0x40000000 (2.0) -> r=7 (8 with ROUND_EN), g=15, b=15, valid_out exactly 3 cycles after acceptance.
REQ-023 r/g/b = 0xBE800000 (-0.25), 0x7FC00000 (NaN), 0x7F800000 (+inf) -> 0, 0, 15; denormal 0x00000001 -> 0.
REQ-024 Stream 10 pixels x=0..9 with ready_in toggling 1-0-0-1 -> outputs in order x=0..9, none lost/duplicated, outputs stable while ready_in=0, ready_out low only when valid_out && !ready_in.
REQ-025 overlay_hit_in=2'b11, overlay0 rgb=F/0/0, overlay1 rgb=0/F/0, block_visible_in=0 -> r=15,g=0,b=0, visible_out=1; hit=2'b00, block_visible_in=0 -> visible_out=0, quantised colour.
REQ-026 Accept 2 pixels, assert rst_n_in low mid-flight for 1 cycle (asynchronous to edge) -> valid_out=0 immediately, no pixel emerges; next pixel valid 3 cycles after acceptance.
